brick_pixel_raster: RTL and testbench

Rasterizer stage directly downstream of the brick draw sequencer. It accepts brick-origin requests (one `draw` strobe with an `x_in`/`y_in` origin) into a small request FIFO. It expands each request into a filled BRICK_W × BRICK_H block of single-pixel plot writes for the VGA framebuffer adapter, emitting one pixel per clock.

---
 rtl/brick_pixel_raster.sv | 209 ++++++++++++++++++++
 tb/tb_brick_pixel_raster.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/brick_pixel_raster.sv
// Brick rasterizer: queues brick-origin requests and expands each into a filled
// BRICK_W x BRICK_H block of one-pixel plots. Define BRICK_RASTER_OUTLINE_EN for outlined bricks.
module brick_pixel_raster #(
  parameter int                     BRICK_W        = 10,
  parameter int                     BRICK_H        = 5,
  parameter int                     COLOUR_W       = 3,
  parameter logic [COLOUR_W-1:0]    FILL_COLOUR    = 3'b110,
  parameter logic [COLOUR_W-1:0]    OUTLINE_COLOUR = 3'b111,
  parameter int                     FIFO_DEPTH     = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                draw,
  input  logic [9:0]          x_in,
  input  logic [9:0]          y_in,
  input  logic                erase,
  output logic                ready,
  output logic                busy,
  output logic                plot,
  output logic [9:0]          x_out,
  output logic [9:0]          y_out,
  output logic [COLOUR_W-1:0] colour,
  output logic                done,
  output logic                overflow
);

  localparam int CXW  = (BRICK_W > 1) ? $clog2(BRICK_W) : 1;
  localparam int CYW  = (BRICK_H > 1) ? $clog2(BRICK_H) : 1;
  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTW = AW + 1;
  localparam int DW   = 21;

  localparam logic [CXW-1:0]  CX_LAST = CXW'(BRICK_W - 1);
  localparam logic [CYW-1:0]  CY_LAST = CYW'(BRICK_H - 1);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLOT,
    S_DONE
  } state_t;

  // request FIFO
  logic [DW-1:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CNTW-1:0] count;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic [DW-1:0]   head;

  // FSM and pixel generator
  state_t                state;
  state_t                state_n;
  logic [CXW-1:0]        cx;
  logic [CXW-1:0]        cx_n;
  logic [CYW-1:0]        cy;
  logic [CYW-1:0]        cy_n;
  logic [9:0]            base_x;
  logic [9:0]            base_x_n;
  logic [9:0]            base_y;
  logic [9:0]            base_y_n;
  logic                  erase_q;
  logic                  erase_n;
  logic                  plot_n;
  logic                  done_n;
  logic [9:0]            x_n;
  logic [9:0]            y_n;
  logic [COLOUR_W-1:0]   colour_n;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign push  = draw && !full;
  assign pop   = (state == S_IDLE) && !empty;
  assign head  = fifo_mem[rd_ptr];

  assign ready = !full;
  assign busy  = !empty || (state != S_IDLE);

  // Storage needs no reset: entries are only read once the count says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {erase, x_in, y_in};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (draw && full) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cx      <= '0;
      cy      <= '0;
      base_x  <= '0;
      base_y  <= '0;
      erase_q <= 1'b0;
      plot    <= 1'b0;
      done    <= 1'b0;
      x_out   <= '0;
      y_out   <= '0;
      colour  <= '0;
    end else begin
      state   <= state_n;
      cx      <= cx_n;
      cy      <= cy_n;
      base_x  <= base_x_n;
      base_y  <= base_y_n;
      erase_q <= erase_n;
      plot    <= plot_n;
      done    <= done_n;
      x_out   <= x_n;
      y_out   <= y_n;
      colour  <= colour_n;
    end
  end

  // cx/cy name the pixel on the outputs this cycle; next-pixel values feed the output registers.
  always_comb begin
    state_n  = state;
    cx_n     = cx;
    cy_n     = cy;
    base_x_n = base_x;
    base_y_n = base_y;
    erase_n  = erase_q;
    plot_n   = 1'b0;
    done_n   = 1'b0;
    x_n      = x_out;
    y_n      = y_out;
    colour_n = colour;

    case (state)
      S_IDLE: begin
        if (!empty) begin
          {erase_n, base_x_n, base_y_n} = head;
          cx_n    = '0;
          cy_n    = '0;
          plot_n  = 1'b1;
          state_n = S_PLOT;
        end
      end
      S_PLOT: begin
        if (cx == CX_LAST) begin
          cx_n = '0;
          if (cy == CY_LAST) begin
            cy_n    = '0;
            done_n  = 1'b1;
            state_n = S_DONE;
          end else begin
            cy_n   = cy + 1'b1;
            plot_n = 1'b1;
          end
        end else begin
          cx_n   = cx + 1'b1;
          plot_n = 1'b1;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    if (plot_n) begin
      x_n      = base_x_n + 10'(cx_n);
      y_n      = base_y_n + 10'(cy_n);
      colour_n = FILL_COLOUR;
`ifdef BRICK_RASTER_OUTLINE_EN
      if ((cx_n == '0) || (cx_n == CX_LAST) || (cy_n == '0) || (cy_n == CY_LAST)) begin
        colour_n = OUTLINE_COLOUR;
      end
`endif
      if (erase_n) begin
        colour_n = '0;
      end
    end
  end

`ifndef BRICK_RASTER_OUTLINE_EN
  logic unused_outline;
  assign unused_outline = ^OUTLINE_COLOUR;
`endif

endmodule

// File: tb/tb_brick_pixel_raster.sv
// Directed self-checking bench for brick_pixel_raster: single brick, FIFO overflow,
// erase with coordinate wrap, outline colours, mid-brick reset and pop/push interplay.
module tb_brick_pixel_raster;

  logic       clk = 1'b0;
  logic       reset;
  logic       draw;
  logic [9:0] x_in;
  logic [9:0] y_in;
  logic       erase;
  logic       ready;
  logic       busy;
  logic       plot;
  logic [9:0] x_out;
  logic [9:0] y_out;
  logic [2:0] colour;
  logic       done;
  logic       overflow;

  int n_cmp = 0;
  int n_err = 0;

  brick_pixel_raster dut (
    .clk      (clk),
    .reset    (reset),
    .draw     (draw),
    .x_in     (x_in),
    .y_in     (y_in),
    .erase    (erase),
    .ready    (ready),
    .busy     (busy),
    .plot     (plot),
    .x_out    (x_out),
    .y_out    (y_out),
    .colour   (colour),
    .done     (done),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Holds a request for one rising edge, returning at the following falling edge.
  task automatic send(input logic e, input logic [9:0] x, input logic [9:0] y);
    draw  = 1'b1;
    erase = e;
    x_in  = x;
    y_in  = y;
    step();
    draw  = 1'b0;
    erase = 1'b0;
  endtask

  int pc, dn, done_at, first_at;
  int nr, prev;
  int rise_t [4];
  int rise_x [4];
  int rise_y [4];
  int bad;
  int exp_x, exp_y;
  logic [2:0] cols [50];
  int done_t, f_t, fx, fy;

  initial begin
    reset = 1'b1;
    draw  = 1'b0;
    erase = 1'b0;
    x_in  = '0;
    y_in  = '0;
    step();
    step();
    chk("rst_plot", plot, 0);
    chk("rst_done", done, 0);
    chk("rst_x", x_out, 0);
    chk("rst_y", y_out, 0);
    chk("rst_colour", colour, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    step();

    // single brick at (20,5)
    send(1'b0, 10'd20, 10'd5);
    chk("t1_plot_before_pop", plot, 0);
    chk("t1_busy_queued", busy, 1);
    step();
    pc = 0; dn = 0; done_at = -1; first_at = -1;
    for (int i = 0; i < 60; i++) begin
      if (plot) begin
        pc++;
        if (pc == 1) begin
          first_at = i;
          chk("t1_first_x", x_out, 20);
          chk("t1_first_y", y_out, 5);
          chk("t1_first_colour", colour, 3'b110);
        end
        if (pc == 11) begin
          chk("t1_11th_x", x_out, 20);
          chk("t1_11th_y", y_out, 6);
        end
        if (pc == 50) begin
          chk("t1_last_x", x_out, 29);
          chk("t1_last_y", y_out, 9);
          chk("t1_last_colour", colour, 3'b110);
        end
      end
      if (done) begin
        dn++;
        done_at = i;
      end
      step();
    end
    chk("t1_first_at", first_at, 0);
    chk("t1_plot_count", pc, 50);
    chk("t1_done_count", dn, 1);
    chk("t1_done_at", done_at, 50);
    chk("t1_busy_end", busy, 0);

    // five draws while a brick is plotting: four fill the FIFO, the fifth overflows
    send(1'b0, 10'd200, 10'd50);
    step();
    chk("t2_a_plotting", plot, 1);
    for (int i = 0; i < 5; i++) begin
      draw = 1'b1;
      x_in = 10'(i * 20);
      y_in = 10'd300;
      step();
      if (i == 3) begin
        chk("t2_ready_full", ready, 0);
        chk("t2_overflow_not_yet", overflow, 0);
      end
    end
    draw = 1'b0;
    chk("t2_overflow_set", overflow, 1);
    chk("t2_busy", busy, 1);
    nr = 0;
    prev = 1;
    for (int t = 0; t < 300; t++) begin
      if (plot && prev == 0) begin
        if (nr < 4) begin
          rise_t[nr] = t;
          rise_x[nr] = int'(x_out);
          rise_y[nr] = int'(y_out);
        end
        nr++;
      end
      prev = int'(plot);
      step();
    end
    chk("t2_brick_count", nr, 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t2_brick%0d_x", k), rise_x[k], k * 20);
      chk($sformatf("t2_brick%0d_y", k), rise_y[k], 300);
    end
    for (int k = 1; k < 4; k++) begin
      chk($sformatf("t2_spacing%0d", k), rise_t[k] - rise_t[k-1], 52);
    end
    chk("t2_busy_end", busy, 0);
    chk("t2_overflow_sticky", overflow, 1);

    // erase at (1020,1022) wraps both axes
    send(1'b1, 10'd1020, 10'd1022);
    step();
    bad = 0;
    for (int n = 0; n < 50; n++) begin
      exp_x = (1020 + n % 10) % 1024;
      exp_y = (1022 + n / 10) % 1024;
      if (!(plot === 1'b1 && x_out === 10'(exp_x) && y_out === 10'(exp_y) && colour === 3'b000)) begin
        bad++;
      end
      if (n == 3) chk("t3_x_1023", x_out, 1023);
      if (n == 4) chk("t3_x_wrap0", x_out, 0);
      if (n == 9) chk("t3_x_5", x_out, 5);
      if (n == 10) chk("t3_y_1023", y_out, 1023);
      if (n == 20) chk("t3_y_wrap0", y_out, 0);
      if (n == 49) begin
        chk("t3_last_x", x_out, 5);
        chk("t3_last_y", y_out, 2);
      end
      step();
    end
    chk("t3_bad_pixels", bad, 0);
    chk("t3_done", done, 1);
    step();
    chk("t3_busy_end", busy, 0);

    // colour map at origin (0,0)
    send(1'b0, 10'd0, 10'd0);
    step();
    for (int n = 0; n < 50; n++) begin
      cols[n] = colour;
      step();
    end
`ifdef BRICK_RASTER_OUTLINE_EN
    chk("t4_px_0_0", cols[0], 3'b111);
    chk("t4_px_9_0", cols[9], 3'b111);
    chk("t4_px_0_4", cols[40], 3'b111);
    chk("t4_px_5_4", cols[45], 3'b111);
`else
    chk("t4_px_0_0", cols[0], 3'b110);
    chk("t4_px_9_0", cols[9], 3'b110);
    chk("t4_px_0_4", cols[40], 3'b110);
    chk("t4_px_5_4", cols[45], 3'b110);
`endif
    chk("t4_px_1_1", cols[11], 3'b110);
    chk("t4_px_8_3", cols[38], 3'b110);
    chk("t4_done", done, 1);
    step();

    // reset at the 20th pixel with two requests queued
    draw = 1'b1; x_in = 10'd100; y_in = 10'd100;
    step();
    x_in = 10'd200;
    step();
    x_in = 10'd300;
    step();
    draw = 1'b0;
    for (int i = 0; i < 18; i++) step();
    chk("t5_pre_plot", plot, 1);
    chk("t5_pre_x", x_out, 109);
    chk("t5_pre_y", y_out, 101);
    chk("t5_pre_busy", busy, 1);
    chk("t5_pre_overflow", overflow, 1);
    reset = 1'b1;
    #1;
    chk("t5_rst_plot", plot, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_overflow", overflow, 0);
    chk("t5_rst_ready", ready, 1);
    chk("t5_rst_busy", busy, 0);
    step();
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    chk("t5_quiet_after_reset", bad, 0);

    // draw lands on the cycle the only entry is popped
    send(1'b0, 10'd40, 10'd60);
    draw = 1'b1; x_in = 10'd500; y_in = 10'd70;
    step();
    draw = 1'b0;
    chk("t6_e_first_plot", plot, 1);
    chk("t6_e_first_x", x_out, 40);
    chk("t6_busy", busy, 1);
    done_t = -1; f_t = -1; fx = -1; fy = -1;
    for (int t = 0; t < 200; t++) begin
      if (done && done_t < 0) done_t = t;
      if (done_t >= 0 && f_t < 0 && plot) begin
        f_t = t;
        fx = int'(x_out);
        fy = int'(y_out);
      end
      step();
    end
    chk("t6_done_seen", (done_t >= 0), 1);
    chk("t6_gap", f_t - done_t, 2);
    chk("t6_f_x", fx, 500);
    chk("t6_f_y", fy, 70);
    chk("t6_busy_end", busy, 0);
    chk("t6_overflow", overflow, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
